// File: rtl/sm_fixed_pkg.sv
// -----------------------------------------------------------------------------
// sm_fixed_pkg
// Shared definitions for the sign-magnitude fixed-point arithmetic blocks
// (adder and subtractor) of the forward-kinematics datapath.
//   N_DEFAULT / Q_DEFAULT : default total width / fractional bit count
//   MAG_MAX               : largest representable magnitude, 2^(N-1)-1
//   op_e                  : magnitude operation selected by stage 1
//   field helpers         : sign/magnitude extraction and canonical packing
// -----------------------------------------------------------------------------
package sm_fixed_pkg;

    localparam int unsigned N_DEFAULT     = 32;
    localparam int unsigned Q_DEFAULT     = 15;
    localparam int unsigned MAG_W_DEFAULT = N_DEFAULT - 1;

    localparam logic [MAG_W_DEFAULT-1:0] MAG_MAX = {MAG_W_DEFAULT{1'b1}};

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // A sign is only kept when the magnitude is non-zero, so -0 never exists.
    function automatic logic sm_canon_sign(input logic sign, input logic mag_nonzero);
        return sign & mag_nonzero;
    endfunction

    function automatic logic sm_sign(input logic [N_DEFAULT-1:0] x);
        return x[N_DEFAULT-1];
    endfunction

    function automatic logic [MAG_W_DEFAULT-1:0] sm_mag(input logic [N_DEFAULT-1:0] x);
        return x[MAG_W_DEFAULT-1:0];
    endfunction

    function automatic logic [N_DEFAULT-1:0] sm_pack(input logic sign,
                                                     input logic [MAG_W_DEFAULT-1:0] mag);
        return {sm_canon_sign(sign, |mag), mag};
    endfunction

endpackage

// File: rtl/sm_fixed_subtractor_pipe_if.sv
// -----------------------------------------------------------------------------
// sm_fixed_subtractor_pipe_if
// Operand/result handshake bundle of the sign-magnitude subtractor.
//   in_valid/in_ready/a/b       : operand channel (producer -> block)
//   out_valid/out_ready/c/ovf   : result channel  (block -> consumer)
// modport slave  : the subtractor itself
// modport master : the environment (producer and consumer)
// -----------------------------------------------------------------------------
interface sm_fixed_subtractor_pipe_if
#(
    parameter int unsigned N = sm_fixed_pkg::N_DEFAULT
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, ovf
    );

endinterface

// File: rtl/sm_mag_addsub.sv
// -----------------------------------------------------------------------------
// sm_mag_addsub
// Combinational magnitude unit. Operands arrive already ordered (big >= small
// is only required for OP_SUB, where it guarantees no borrow).
//   big_mag, small_mag : W-bit magnitudes
//   op                 : OP_ADD or OP_SUB
//   mag                : W-bit result magnitude (saturated on add overflow)
//   sat                : add overflowed and the magnitude was clamped
// -----------------------------------------------------------------------------
module sm_mag_addsub
    import sm_fixed_pkg::*;
#(
    parameter int unsigned W = MAG_W_DEFAULT
)
(
    input  logic [W-1:0] big_mag,
    input  logic [W-1:0] small_mag,
    input  op_e          op,
    output logic [W-1:0] mag,
    output logic         sat
);

    logic [W:0] sum_s;

    // Magnitude add with carry-out saturation, or borrow-free ordered subtract.
    always_comb begin
        sum_s = {1'b0, big_mag} + {1'b0, small_mag};
        mag   = {W{1'b0}};
        sat   = 1'b0;
        case (op)
            OP_ADD: begin
                if (sum_s[W]) begin
                    mag = {W{1'b1}};
                    sat = 1'b1;
                end else begin
                    mag = sum_s[W-1:0];
                    sat = 1'b0;
                end
            end
            OP_SUB: begin
                mag = big_mag - small_mag;
                sat = 1'b0;
            end
            default: begin
                mag = {W{1'b0}};
                sat = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sm_fixed_subtractor_pipe.sv
// -----------------------------------------------------------------------------
// sm_fixed_subtractor_pipe
// Two-stage pipelined sign-magnitude subtractor c = a - b with valid/ready
// backpressure, magnitude saturation (ovf) and canonical zero.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of sm_fixed_subtractor_pipe_if (a, b in; c, ovf out)
// Stage 1 registers effective signs, ordered magnitudes, op and result sign;
// stage 2 is the output register fed by sm_mag_addsub.
// -----------------------------------------------------------------------------
module sm_fixed_subtractor_pipe
    import sm_fixed_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
)
(
    input  logic                     clk,
    input  logic                     rst,
    sm_fixed_subtractor_pipe_if.slave bus
);

    localparam int unsigned W = N - 1;

    // Stage 1 state
    logic         s1_valid_q, s1_valid_d;
    op_e          s1_op_q,    s1_op_d;
    logic         s1_sign_q,  s1_sign_d;
    logic [W-1:0] s1_big_q,   s1_big_d;
    logic [W-1:0] s1_small_q, s1_small_d;

    // Stage 2 (output) state
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] c_q,         c_d;
    logic         ovf_q,       ovf_d;

    // Combinational helpers
    logic [W-1:0] a_mag_s, b_mag_s;
    logic         a_sign_s, nb_sign_s, a_ge_s;
    logic         s1_adv_s, s2_adv_s, in_xfer_s;
    logic [W-1:0] mag_s;
    logic         sat_s;

    // Handshake control and stage-1 capture of a + (-b) operands.
    always_comb begin
        a_mag_s   = bus.a[W-1:0];
        b_mag_s   = bus.b[W-1:0];
        // -0 on either input collapses to +0; b's sign is inverted for -b.
        a_sign_s  = sm_canon_sign(bus.a[N-1], |a_mag_s);
        nb_sign_s = sm_canon_sign(~bus.b[N-1], |b_mag_s);
        a_ge_s    = (a_mag_s >= b_mag_s);

        s2_adv_s  = !out_valid_q || bus.out_ready;
        s1_adv_s  = !s1_valid_q || s2_adv_s;
        in_xfer_s = bus.in_valid && s1_adv_s;

        s1_op_d    = s1_op_q;
        s1_sign_d  = s1_sign_q;
        s1_big_d   = s1_big_q;
        s1_small_d = s1_small_q;

        if (s1_adv_s) begin
            s1_valid_d = bus.in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (in_xfer_s) begin
            s1_big_d   = a_ge_s ? a_mag_s : b_mag_s;
            s1_small_d = a_ge_s ? b_mag_s : a_mag_s;
            if (a_sign_s == nb_sign_s) begin
                s1_op_d   = OP_ADD;
                s1_sign_d = a_sign_s;
            end else begin
                s1_op_d   = OP_SUB;
                // Larger magnitude wins; a tie yields zero and is cleared later.
                s1_sign_d = a_ge_s ? a_sign_s : nb_sign_s;
            end
        end else begin
            s1_op_d    = s1_op_q;
            s1_sign_d  = s1_sign_q;
            s1_big_d   = s1_big_q;
            s1_small_d = s1_small_q;
        end
    end

    sm_mag_addsub #(.W(W)) u_mag_addsub (
        .big_mag   (s1_big_q),
        .small_mag (s1_small_q),
        .op        (s1_op_q),
        .mag       (mag_s),
        .sat       (sat_s)
    );

    // Stage-2 output register: holds while stalled, loads when stage 1 moves.
    always_comb begin
        if (s2_adv_s) begin
            out_valid_d = s1_valid_q;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (s2_adv_s && s1_valid_q) begin
            c_d   = {sm_canon_sign(s1_sign_q, |mag_s), mag_s};
            ovf_d = sat_s;
        end else begin
            c_d   = c_q;
            ovf_d = ovf_q;
        end
    end

    // Pipeline state flops; reset empties both stages and clears the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ADD;
            s1_sign_q   <= 1'b0;
            s1_big_q    <= {W{1'b0}};
            s1_small_q  <= {W{1'b0}};
            out_valid_q <= 1'b0;
            c_q         <= {N{1'b0}};
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_sign_q   <= s1_sign_d;
            s1_big_q    <= s1_big_d;
            s1_small_q  <= s1_small_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = s1_adv_s;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: doc/sm_fixed_subtractor_pipe.md
# sm_fixed_subtractor_pipe

Pipelined sign-magnitude fixed-point subtractor computing c = a − b on N-bit operands with Q fractional bits. It uses the same number format as the datapath's existing fixed-point adder. It sits alongside that adder in the forward-kinematics arithmetic path. It adds a valid/ready handshake with full backpressure, saturation with an overflow flag, and canonical zero, so producers and consumers can stall independently.

## Interface
- Q, 15, fractional bit count. Informational only; the arithmetic does not depend on Q.
- N, 32, total width. Bit N-1 is the sign; bits N-2:0 are the magnitude.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- in_valid  input  1  operand pair a/b is valid this cycle.
- in_ready  output  1  block accepts the operand pair this cycle.
- a  input  N  minuend, sign-magnitude.
- b  input  N  subtrahend, sign-magnitude.
- out_valid  output  1  c/ovf hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- c  output  N  result a − b, sign-magnitude.
- ovf  output  1  the magnitude saturated for this result.

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- The subtraction is computed as a + (−b), where −b is b with its sign bit inverted. Inputs of −0 are treated as +0.
- Stage 1 (register S1): captures the effective signs and magnitudes, then:
  - compares |a| against |b|;
  - decides the operation: add if the effective signs are equal, subtract otherwise;
  - orders the magnitudes larger/smaller;
  - precomputes the result sign.
- Stage 2 (register S2 = output):
  - Add case: the magnitude is |a|+|b| computed at N bits. If bit N-1 of the sum is set, the magnitude saturates to 2^(N-1)−1 and ovf=1; the sign is the common sign.
  - Subtract case: magnitude = larger − smaller, which never overflows. The sign is the sign of the larger-magnitude operand. On equal magnitudes the result is +0.
  - Any zero magnitude forces the sign to 0, so the block never emits −0.
- Backpressure:
  - A stage advances when it is empty or the stage downstream of it advances.
  - in_ready = !s1_valid || !out_valid || out_ready. It is combinational from out_ready, with no path from in_valid.
  - While out_valid && !out_ready, c and ovf hold stable.
- Results emerge in the same order as the inputs were accepted. No drops, no duplicates.

## Timing
- Latency: 2 cycles from the input transfer to out_valid when no stall occurs.
- Throughput: 1 result per cycle while out_ready is held high.
- Reset (asserted asynchronously, released synchronously to clk):
  - S1 and S2 valid bits clear; out_valid=0.
  - c=0, ovf=0.
  - in_ready=1.
- Reset mid-operation discards all in-flight operands. The first output after release comes from the first post-reset input transfer.
- Simultaneous output transfer and new input on a full pipeline: both stages advance in the same cycle, so there is no bubble.
- Pipeline full with out_ready=0: in_ready=0. At most 2 results are buffered.
- Simultaneous assertion of in_valid and reset: the input is ignored.

## Structure
- Shared package sm_fixed_pkg holds:
  - default N and Q;
  - MAG_MAX = 2^(N-1)−1;
  - the sign-magnitude field helpers shared with the adder.
- One sub-module is natural: sm_mag_addsub. It is purely combinational: it takes the ordered magnitudes and the op, and returns the N-1-bit magnitude and a saturate flag. It is instantiated in stage 2.
- The top level contains the two stage registers, their valid bits, and the ready logic.

## Test plan
- 1.5 − 0.5: a=0x0000C000, b=0x00004000 -> c=0x00008000, ovf=0, out_valid exactly 2 cycles after the transfer.
- 0.5 − 1.5: a=0x00004000, b=0x0000C000 -> c=0x80008000, ovf=0.
- Zero results:
  - −1.0 − (−1.0): a=0x80008000, b=0x80008000 -> c=0x00000000, sign 0.
  - a=0x80000000 (−0), b=0 -> c=0x00000000.
- Saturation: a=0x7FFFFFFF, b=0x80000001 -> c=0x7FFFFFFF, ovf=1.
  - Mirror case: a=0xFFFFFFFF, b=0x00000001 -> c=0xFFFFFFFF, ovf=1.
- Backpressure:
  - Stream 4 back-to-back inputs with out_ready=0 for cycles 0–5. in_ready falls after 2 transfers, and c is stable while stalled.
  - Release out_ready: all 4 results appear in order, 1 per cycle, none lost.
- Mid-stream reset: assert rst low while 2 results are in flight. out_valid=0, c=0 and in_ready=1 take effect immediately. After release, only post-reset inputs produce outputs.
